// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard: ecall serialisation FSM states and counter sizing.
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StWait,
    StIssueEc
  } hz_state_e;

  // Counter wide enough to hold 0..max_inflight inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_inflight);
    return $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle of the hazard scoreboard: master is the pipeline, slave is the scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned REG_IDX_W    = 5,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned NUM_FWD      = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned DATA_WIDTH   = 64
);
  import hazard_pkg::*;

  localparam int unsigned CntW = cnt_width(MAX_INFLIGHT);

  logic                                 id_valid;
  logic [NUM_SRC-1:0][REG_IDX_W-1:0]    id_src_reg;
  logic [REG_IDX_W-1:0]                 id_dst_reg;
  logic                                 id_dst_long;
  logic                                 id_ecall;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   rf_data;
  logic [NUM_FWD-1:0]                   fwd_valid;
  logic [NUM_FWD-1:0][REG_IDX_W-1:0]    fwd_reg;
  logic [NUM_FWD-1:0][DATA_WIDTH-1:0]   fwd_data;
  logic                                 wb_valid;
  logic [REG_IDX_W-1:0]                 wb_dst_reg;
  logic                                 flush;
  logic                                 ecall_done;
  logic                                 issue;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   id_src_val;
  logic                                 ecall_req;
  logic [CntW-1:0]                      inflight;
  logic                                 sb_error;

  modport master (
    output id_valid, id_src_reg, id_dst_reg, id_dst_long, id_ecall, rf_data,
    output fwd_valid, fwd_reg, fwd_data, wb_valid, wb_dst_reg, flush, ecall_done,
    input  issue, id_src_val, ecall_req, inflight, sb_error
  );

  modport slave (
    input  id_valid, id_src_reg, id_dst_reg, id_dst_long, id_ecall, rf_data,
    input  fwd_valid, fwd_reg, fwd_data, wb_valid, wb_dst_reg, flush, ecall_done,
    output issue, id_src_val, ecall_req, inflight, sb_error
  );

endinterface

// File: rtl/fwd_select.sv
// Priority operand mux for one source: lowest-index matching producer wins, else register file.
module fwd_select #(
  parameter int unsigned NUM_FWD    = 2,
  parameter int unsigned REG_IDX_W  = 5,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [REG_IDX_W-1:0]                src_reg,
  input  logic [DATA_WIDTH-1:0]               rf_data,
  input  logic [NUM_FWD-1:0]                  fwd_valid,
  input  logic [NUM_FWD-1:0][REG_IDX_W-1:0]   fwd_reg,
  input  logic [NUM_FWD-1:0][DATA_WIDTH-1:0]  fwd_data,
  output logic [DATA_WIDTH-1:0]               src_val
);

  logic hit;

  always_comb begin
    src_val = rf_data;
    hit     = 1'b0;
    for (int i = 0; i < int'(NUM_FWD); i++) begin
      if (!hit && fwd_valid[i] && fwd_reg[i] == src_reg) begin
        src_val = fwd_data[i];
        hit     = 1'b1;
      end
    end
    // x0 is hardwired zero regardless of what producers claim to write.
    if (src_reg == '0) begin
      src_val = '0;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard for long-latency writes, operand forwarding and ecall drain/hold.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned REG_IDX_W    = 5,
  parameter int unsigned NUM_SRC      = 2,
  parameter int unsigned NUM_FWD      = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned DATA_WIDTH   = 64
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  bus
);

  localparam int unsigned CntW       = cnt_width(MAX_INFLIGHT);
  localparam int unsigned NumEntries = 1 << REG_IDX_W;

  typedef logic [CntW-1:0] cnt_t;

  // Entries at or above NUM_REGS are never incremented, so they always read as zero.
  cnt_t      cnt_q [NumEntries];
  cnt_t      cnt_d [NumEntries];
  cnt_t      inflight_q, inflight_d;
  hz_state_e state_q;
  logic      ecall_req_q;
  logic      sb_error_q, sb_error_d;

  logic hazard, full, permit, issue;
  logic inc_any, dec_any, same_reg, dec_ok, orphan;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_val;

  // Hazards use registered counts only; a same-cycle retirement still stalls.
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      hazard = hazard | (bus.id_src_reg[s] != '0 && cnt_q[bus.id_src_reg[s]] != '0);
    end
  end

  always_comb begin
    full   = bus.id_dst_long && inflight_q == cnt_t'(MAX_INFLIGHT);
    permit = (state_q == StRun && !bus.id_ecall) || state_q == StIssueEc;
    issue  = bus.id_valid && !bus.flush && !hazard && !full && permit;
  end

  always_comb begin
    inc_any  = issue && bus.id_dst_long && bus.id_dst_reg != '0;
    dec_any  = bus.wb_valid && bus.wb_dst_reg != '0;
    same_reg = inc_any && bus.id_dst_reg == bus.wb_dst_reg;
    // A retirement racing an issue to the same register cancels out, even at count zero.
    dec_ok   = dec_any && (cnt_q[bus.wb_dst_reg] != '0 || same_reg);
    orphan   = dec_any && !dec_ok;

    for (int r = 0; r < int'(NumEntries); r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0 && r < int'(NUM_REGS)) begin
        if (inc_any && bus.id_dst_reg == REG_IDX_W'(r) &&
            !(dec_ok && bus.wb_dst_reg == REG_IDX_W'(r))) begin
          cnt_d[r] = cnt_q[r] + cnt_t'(1);
        end else if (dec_ok && bus.wb_dst_reg == REG_IDX_W'(r) &&
                     !(inc_any && bus.id_dst_reg == REG_IDX_W'(r))) begin
          cnt_d[r] = cnt_q[r] - cnt_t'(1);
        end
      end
    end

    inflight_d = inflight_q + cnt_t'(inc_any) - cnt_t'(dec_ok);
    sb_error_d = sb_error_q | orphan;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(NumEntries); r++) begin
        cnt_q[r] <= '0;
      end
      inflight_q <= '0;
      sb_error_q <= 1'b0;
    end else begin
      for (int r = 0; r < int'(NumEntries); r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      inflight_q <= inflight_d;
      sb_error_q <= sb_error_d;
    end
  end

  // Ecall serialisation: drain long writes, request, then let the ecall issue once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StRun;
      ecall_req_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.id_valid && bus.id_ecall && !bus.flush) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (bus.flush) begin
            state_q <= StRun;
          end else if (inflight_q == '0) begin
            state_q     <= StWait;
            ecall_req_q <= 1'b1;
          end
        end
        StWait: begin
          if (bus.flush) begin
            state_q     <= StRun;
            ecall_req_q <= 1'b0;
          end else if (bus.ecall_done) begin
            state_q     <= StIssueEc;
            ecall_req_q <= 1'b0;
          end
        end
        StIssueEc: begin
          state_q <= StRun;
        end
        default: begin
          state_q     <= StRun;
          ecall_req_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar s = 0; s < int'(NUM_SRC); s++) begin : g_fwd
    fwd_select #(
      .NUM_FWD    (NUM_FWD),
      .REG_IDX_W  (REG_IDX_W),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_fwd_select (
      .src_reg   (bus.id_src_reg[s]),
      .rf_data   (bus.rf_data[s]),
      .fwd_valid (bus.fwd_valid),
      .fwd_reg   (bus.fwd_reg),
      .fwd_data  (bus.fwd_data),
      .src_val   (src_val[s])
    );
  end

  assign bus.issue      = issue;
  assign bus.id_src_val = src_val;
  assign bus.ecall_req  = ecall_req_q;
  assign bus.inflight   = inflight_q;
  assign bus.sb_error   = sb_error_q;

endmodule
